// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM state encoding and default geometry for the
//               unified memory block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_addr_width_dflt = 8;
    localparam int c_data_width_dflt = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DUMP_FETCH = 2'd1,
        ST_DUMP_SEND  = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port storage with synchronous read and write enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width_dflt,
    parameter int DATA_WIDTH = c_data_width_dflt
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read data only changes on a read, so it is stable across idle and write cycles.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/unified_memory.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory
// Description : CPU-accessible memory with a preload port and a post-program
//               dump stream, all muxed onto one single-port array.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_memory
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width_dflt,
    parameter int DATA_WIDTH = c_data_width_dflt
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_enable_i,
    input  logic                  mem_rd_en_i,
    input  logic                  mem_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_value_i,
    output logic [DATA_WIDTH-1:0] mem_value_o,
    input  logic                  end_program_i,
    input  logic                  load_valid_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  dump_valid_o,
    output logic [ADDR_WIDTH-1:0] dump_addr_o,
    output logic [DATA_WIDTH-1:0] dump_data_o,
    input  logic                  dump_ready_i,
    output logic                  dump_done_o,
    output logic                  protocol_err_o
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic                  r_err;
    logic                  r_cpu_rd_q;
    logic [DATA_WIDTH-1:0] r_value_hold;

    logic                  w_run;
    logic                  w_cpu_rd;
    logic                  w_cpu_wr;
    logic                  w_proto_bad;
    logic                  w_load_fire;

    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [ADDR_WIDTH-1:0] w_arr_addr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    assign w_run       = (r_state == ST_RUN);
    assign w_cpu_rd    = w_run & mem_rd_en_i & ~mem_wr_en_i;
    assign w_cpu_wr    = w_run & mem_wr_en_i & ~mem_rd_en_i;
    assign w_proto_bad = w_run & ((mem_rd_en_i & mem_wr_en_i) |
                                  (mem_enable_i != (mem_rd_en_i | mem_wr_en_i)));

    // Loads also yield to stray rd/wr enables so the CPU always owns the port.
    assign load_ready_o = w_run & ~mem_enable_i & ~mem_rd_en_i & ~mem_wr_en_i;
    assign w_load_fire  = load_valid_i & load_ready_o;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_arr_we     = 1'b0;
        w_arr_re     = 1'b0;
        w_arr_addr   = r_cnt;
        w_arr_wdata  = mem_value_i;
        case (r_state)
            ST_RUN: begin
                if (w_cpu_rd) begin
                    w_arr_re   = 1'b1;
                    w_arr_addr = mem_addr_i;
                end else if (w_cpu_wr) begin
                    w_arr_we   = 1'b1;
                    w_arr_addr = mem_addr_i;
                end else if (w_load_fire) begin
                    w_arr_we    = 1'b1;
                    w_arr_addr  = load_addr_i;
                    w_arr_wdata = load_data_i;
                end
                if (end_program_i) begin
                    w_state_next = ST_DUMP_FETCH;
                    w_cnt_next   = '0;
                end
            end
            ST_DUMP_FETCH: begin
                w_arr_re     = 1'b1;
                w_state_next = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                if (dump_ready_i) begin
                    if (r_cnt != c_last_addr) begin
                        w_cnt_next   = r_cnt + 1'b1;
                        w_state_next = ST_DUMP_FETCH;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_cpu_rd_q   <= 1'b0;
            r_value_hold <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_err      <= r_err | w_proto_bad;
            r_cpu_rd_q <= w_cpu_rd;
            if (r_cpu_rd_q) begin
                r_value_hold <= w_arr_rdata;
            end
        end
    end

    // The array's read register is the CPU data in the cycle after a read;
    // r_value_hold keeps it once the array is reused for loads or the dump.
    assign mem_value_o    = r_cpu_rd_q ? w_arr_rdata : r_value_hold;
    assign dump_valid_o   = (r_state == ST_DUMP_SEND);
    assign dump_addr_o    = r_cnt;
    assign dump_data_o    = (r_state == ST_DUMP_SEND) ? w_arr_rdata : '0;
    assign dump_done_o    = (r_state == ST_DONE);
    assign protocol_err_o = r_err;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_array (
        .clk     (clk_i),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_unified_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_memory
// Description : Directed self-checking bench; a default-size instance for CPU
//               and load traffic, an 8-word instance for the dump stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: default geometry
    logic        a_rst, a_en, a_rd, a_wr, a_endp, a_lv, a_dr;
    logic [7:0]  a_addr, a_la;
    logic [15:0] a_wd, a_ld;
    logic [15:0] a_val, a_dd;
    logic [7:0]  a_da;
    logic        a_lr, a_dv, a_done, a_err;

    // Instance B: 8 words
    logic        b_rst, b_en, b_rd, b_wr, b_endp, b_lv, b_dr;
    logic [2:0]  b_addr, b_la;
    logic [15:0] b_wd, b_ld;
    logic [15:0] b_val, b_dd;
    logic [2:0]  b_da;
    logic        b_lr, b_dv, b_done, b_err;

    unified_memory u_dut_a (
        .clk_i          (clk),
        .rst_i          (a_rst),
        .mem_enable_i   (a_en),
        .mem_rd_en_i    (a_rd),
        .mem_wr_en_i    (a_wr),
        .mem_addr_i     (a_addr),
        .mem_value_i    (a_wd),
        .mem_value_o    (a_val),
        .end_program_i  (a_endp),
        .load_valid_i   (a_lv),
        .load_addr_i    (a_la),
        .load_data_i    (a_ld),
        .load_ready_o   (a_lr),
        .dump_valid_o   (a_dv),
        .dump_addr_o    (a_da),
        .dump_data_o    (a_dd),
        .dump_ready_i   (a_dr),
        .dump_done_o    (a_done),
        .protocol_err_o (a_err)
    );

    unified_memory #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) u_dut_b (
        .clk_i          (clk),
        .rst_i          (b_rst),
        .mem_enable_i   (b_en),
        .mem_rd_en_i    (b_rd),
        .mem_wr_en_i    (b_wr),
        .mem_addr_i     (b_addr),
        .mem_value_i    (b_wd),
        .mem_value_o    (b_val),
        .end_program_i  (b_endp),
        .load_valid_i   (b_lv),
        .load_addr_i    (b_la),
        .load_data_i    (b_ld),
        .load_ready_o   (b_lr),
        .dump_valid_o   (b_dv),
        .dump_addr_o    (b_da),
        .dump_data_o    (b_dd),
        .dump_ready_i   (b_dr),
        .dump_done_o    (b_done),
        .protocol_err_o (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int beats;
    int stalls;
    int done_cyc;
    int found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; a_en = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_endp = 1'b0;
        a_lv = 1'b0; a_dr = 1'b0; a_addr = '0; a_la = '0; a_wd = '0; a_ld = '0;
        b_rst = 1'b0; b_en = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_endp = 1'b0;
        b_lv = 1'b0; b_dr = 1'b0; b_addr = '0; b_la = '0; b_wd = '0; b_ld = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_val",  32'(a_val),  32'h0);
        check("rst_err",  32'(a_err),  32'h0);
        check("rst_dv",   32'(a_dv),   32'h0);
        check("rst_da",   32'(a_da),   32'h0);
        check("rst_dd",   32'(a_dd),   32'h0);
        check("rst_done", 32'(a_done), 32'h0);
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);

        // Load 0xBEEF at 0x05, read it back
        a_lv = 1'b1; a_la = 8'h05; a_ld = 16'hBEEF;
        #1 check("load_ready_idle", 32'(a_lr), 32'h1);
        @(negedge clk);
        a_lv = 1'b0;
        a_en = 1'b1; a_rd = 1'b1; a_addr = 8'h05;
        @(negedge clk);
        check("rd_loaded_05", 32'(a_val), 32'hBEEF);
        a_en = 1'b0; a_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("val_hold_idle", 32'(a_val), 32'hBEEF);

        // CPU write/read, then illegal rd+wr
        a_en = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_wd = 16'h1234;
        @(negedge clk);
        a_wr = 1'b0; a_rd = 1'b1;
        @(negedge clk);
        check("rd_after_wr", 32'(a_val), 32'h1234);
        check("err_clean",   32'(a_err), 32'h0);
        a_addr = 8'h05;
        @(negedge clk);
        a_wr = 1'b1; a_addr = 8'h10; a_wd = 16'hFFFF;
        @(negedge clk);
        check("err_rdwr",  32'(a_err), 32'h1);
        check("rdwr_hold", 32'(a_val), 32'hBEEF);
        a_wr = 1'b0;
        @(negedge clk);
        check("rdwr_no_write", 32'(a_val), 32'h1234);
        a_en = 1'b0; a_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("err_sticky", 32'(a_err), 32'h1);

        // Reset clears flag; enable mismatch still reads and flags
        a_rst = 1'b0;
        #1 check("err_rst_clear", 32'(a_err), 32'h0);
        check("val_rst_clear", 32'(a_val), 32'h0);
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_en = 1'b0; a_rd = 1'b1; a_addr = 8'h05;
        @(negedge clk);
        check("mismatch_rd",  32'(a_val), 32'hBEEF);
        check("mismatch_err", 32'(a_err), 32'h1);
        a_rd = 1'b0; a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);

        // Load stalls behind CPU read
        a_en = 1'b1; a_rd = 1'b1; a_addr = 8'h10;
        a_lv = 1'b1; a_la = 8'h20; a_ld = 16'hCAFE;
        #1 check("load_blocked", 32'(a_lr), 32'h0);
        @(negedge clk);
        check("rd_10_kept", 32'(a_val), 32'h1234);
        a_en = 1'b0; a_rd = 1'b0;
        #1 check("load_unblocked", 32'(a_lr), 32'h1);
        @(negedge clk);
        a_lv = 1'b0;
        a_en = 1'b1; a_rd = 1'b1; a_addr = 8'h20;
        @(negedge clk);
        check("rd_loaded_20", 32'(a_val), 32'hCAFE);
        check("err_after_load", 32'(a_err), 32'h0);
        a_en = 1'b0; a_rd = 1'b0;

        // Instance B: preload and full-speed dump
        for (int i = 0; i < 8; i++) begin
            b_lv = 1'b1; b_la = 3'(i); b_ld = 16'(16'h100 + i);
            @(negedge clk);
        end
        b_lv = 1'b0; b_dr = 1'b1; b_endp = 1'b1;
        @(negedge clk);
        b_endp = 1'b0;
        check("dump_fetch_dv", 32'(b_dv), 32'h0);
        check("dump_lr_low",   32'(b_lr), 32'h0);
        beats = 0; done_cyc = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (b_done && done_cyc == 0) done_cyc = c;
            if (b_dv) begin
                check("beat_addr", 32'(b_da), 32'(beats));
                check("beat_data", 32'(b_dd), 32'(16'h100 + beats));
                beats++;
            end
        end
        check("dump_beats",   32'(beats),    32'd8);
        check("dump_done_at", 32'(done_cyc), 32'd16);
        check("done_flag",    32'(b_done),   32'h1);
        check("done_dv_low",  32'(b_dv),     32'h0);

        // Backpressure at beat 3
        b_rst = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_endp = 1'b1; b_dr = 1'b1;
        @(negedge clk);
        b_endp = 1'b0;
        beats = 0; stalls = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (b_done) break;
            if (b_dv) begin
                if (b_da == 3'd3 && stalls < 5) begin
                    b_dr = 1'b0;
                    check("stall_addr", 32'(b_da), 32'd3);
                    check("stall_data", 32'(b_dd), 32'h103);
                    stalls++;
                end else begin
                    b_dr = 1'b1;
                    check("bp_beat_addr", 32'(b_da), 32'(beats));
                    check("bp_beat_data", 32'(b_dd), 32'(16'h100 + beats));
                    beats++;
                end
            end
        end
        check("bp_beats",  32'(beats),  32'd8);
        check("bp_stalls", 32'(stalls), 32'd5);
        check("bp_done",   32'(b_done), 32'h1);

        // Reset mid-dump while CPU/load traffic is ignored
        b_rst = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_endp = 1'b1; b_dr = 1'b1;
        @(negedge clk);
        b_endp = 1'b0;
        b_en = 1'b1; b_rd = 1'b1; b_wr = 1'b1; b_wd = 16'hDEAD; b_lv = 1'b1; b_la = 3'd2; b_ld = 16'hDEAD;
        found = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (b_dv && b_da == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("beat4_found",   32'(found), 32'd1);
        check("dump_beat4_dd", 32'(b_dd),  32'h104);
        check("dump_lr_zero",  32'(b_lr),  32'h0);
        check("dump_err_zero", 32'(b_err), 32'h0);
        b_rst = 1'b0;
        #1;
        check("abort_dv",   32'(b_dv),   32'h0);
        check("abort_da",   32'(b_da),   32'h0);
        check("abort_dd",   32'(b_dd),   32'h0);
        check("abort_done", 32'(b_done), 32'h0);
        check("abort_val",  32'(b_val),  32'h0);
        b_en = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_lv = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        check("abort_run_lr", 32'(b_lr), 32'h1);
        b_en = 1'b1; b_rd = 1'b1; b_addr = 3'd2;
        @(negedge clk);
        check("abort_rd_02",  32'(b_val), 32'h102);
        check("abort_err",    32'(b_err), 32'h0);
        b_en = 1'b0; b_rd = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
